// File: rtl/atualiza_linha_pipe.sv
// Two-stage row updater for the time-windowed bloom filter: ages a row to the
// current stamp, optionally ORs a mark into the newest bucket, and restamps it.
module atualiza_linha_pipe #(
    parameter int DATA_WIDTH     = 72,
    parameter int NUM_BUCKETS    = 14,
    parameter int BUCKET_SZ      = 4,
    parameter int BITS_SHIFT     = $clog2(NUM_BUCKETS),
    parameter int BLOOM_INIT_POS = 16,
    parameter int LOOP_W         = BLOOM_INIT_POS - BITS_SHIFT,
    parameter int SHIFT_W        = $clog2(NUM_BUCKETS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [BITS_SHIFT-1:0] in_cur_bucket,
    input  logic [LOOP_W-1:0]     in_cur_loop,
    input  logic                  in_insert,
    input  logic [BUCKET_SZ-1:0]  in_mark,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [SHIFT_W-1:0]    out_shift,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_sticky
);
    localparam int BLOOM_W = DATA_WIDTH - BLOOM_INIT_POS;
    localparam int T_W     = LOOP_W + BITS_SHIFT + 1;

    // Handshake: a beat transfers on any edge where valid and ready are both 1;
    // a stage advances when it is empty or its successor takes its beat.
    logic s1_valid, s2_valid, s1_adv, s2_adv;
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    logic [LOOP_W-1:0]     d_loop;
    logic [BITS_SHIFT-1:0] d_bucket;
    logic [T_W-1:0]        t_data, t_cur, delta;
    logic                  err_c;
    logic [SHIFT_W-1:0]    shift_c;

    always_comb begin
        d_loop   = in_data[LOOP_W-1:0];
        d_bucket = in_data[BLOOM_INIT_POS-1:LOOP_W];
        t_data   = T_W'(d_loop) * T_W'(NUM_BUCKETS) + T_W'(d_bucket);
        t_cur    = T_W'(in_cur_loop) * T_W'(NUM_BUCKETS) + T_W'(in_cur_bucket);
        delta    = t_cur - t_data;
        // Loop wrap is not modelled: a stamp from the "future" is always an error.
        err_c    = (t_cur < t_data) || (int'(d_bucket) >= NUM_BUCKETS) ||
                   (int'(in_cur_bucket) >= NUM_BUCKETS);
        shift_c  = '0;
        if (!err_c) begin
            if (delta >= T_W'(NUM_BUCKETS))
                shift_c = SHIFT_W'(NUM_BUCKETS);
            else
                shift_c = delta[SHIFT_W-1:0];
        end
    end

    logic [DATA_WIDTH-1:0] s1_data;
    logic [BITS_SHIFT-1:0] s1_cur_bucket;
    logic [LOOP_W-1:0]     s1_cur_loop;
    logic                  s1_insert, s1_err;
    logic [BUCKET_SZ-1:0]  s1_mark;
    logic [SHIFT_W-1:0]    s1_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_data       <= '0;
            s1_cur_bucket <= '0;
            s1_cur_loop   <= '0;
            s1_insert     <= 1'b0;
            s1_mark       <= '0;
            s1_err        <= 1'b0;
            s1_shift      <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data       <= in_data;
                s1_cur_bucket <= in_cur_bucket;
                s1_cur_loop   <= in_cur_loop;
                s1_insert     <= in_insert;
                s1_mark       <= in_mark;
                s1_err        <= err_c;
                s1_shift      <= shift_c;
            end
        end
    end

    logic [BLOOM_W-1:0]    bloom_new;
    logic [DATA_WIDTH-1:0] next_data;

    always_comb begin
        // A shift of NUM_BUCKETS moves the whole field out, leaving zeros.
        bloom_new = s1_data[DATA_WIDTH-1:BLOOM_INIT_POS] >> (int'(s1_shift) * BUCKET_SZ);
        if (s1_insert)
            bloom_new[BLOOM_W-1 -: BUCKET_SZ] = bloom_new[BLOOM_W-1 -: BUCKET_SZ] | s1_mark;
        if (s1_err)
            next_data = s1_data;
        else
            next_data = {bloom_new, s1_cur_bucket, s1_cur_loop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid   <= 1'b0;
            out_data   <= '0;
            out_shift  <= '0;
            out_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data  <= next_data;
                    out_shift <= s1_err ? '0 : s1_shift;
                    out_err   <= s1_err;
                end
            end
            if (s2_valid && out_ready && out_err)
                err_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_atualiza_linha_pipe.sv
// Directed bench for atualiza_linha_pipe: aging, insert, saturation, errors,
// backpressure and reset mid-stall, with hand-computed expected rows.
module tb_atualiza_linha_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic [71:0] in_data;
    logic [3:0]  in_cur_bucket;
    logic [11:0] in_cur_loop;
    logic        in_insert;
    logic [3:0]  in_mark;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] out_data;
    logic [3:0]  out_shift;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic        err_sticky;

    int checks = 0;
    int errors = 0;
    logic [71:0] exp_q[$];

    atualiza_linha_pipe dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_cur_bucket(in_cur_bucket),
        .in_cur_loop(in_cur_loop), .in_insert(in_insert), .in_mark(in_mark),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_shift(out_shift), .out_err(out_err), .out_valid(out_valid),
        .out_ready(out_ready), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Drives one beat with out_ready=1, returns the output beat and the latency
    // in cycles from the input cycle to the cycle out_valid is seen.
    task automatic drive_beat(input logic [71:0] d, input logic [3:0] cb, input logic [11:0] cl,
                              input logic ins, input logic [3:0] mk,
                              output logic [71:0] od, output logic [3:0] osh,
                              output logic oe, output int lat);
        int w;
        @(negedge clk);
        out_ready = 1'b1;
        in_data = d; in_cur_bucket = cb; in_cur_loop = cl; in_insert = ins; in_mark = mk;
        in_valid = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 10) begin
            @(negedge clk); #1; w++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid && lat < 10) begin
            @(negedge clk); #1; lat++;
        end
        od = out_data; osh = out_shift; oe = out_err;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_cur_bucket = '0; in_cur_loop = '0; in_insert = 1'b0; in_mark = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 72'd0 || out_shift !== 4'd0 ||
            out_err !== 1'b0 || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h shift=%0d err=%b sticky=%b, expected all 0",
                     out_valid, out_data, out_shift, out_err, err_sticky);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_same_stamp();
        logic [71:0] od; logic [3:0] osh; logic oe; int lat;
        logic [71:0] d;
        d = {56'hFEDCBA98765432, 4'd3, 12'd5};
        drive_beat(d, 4'd3, 12'd5, 1'b0, 4'h0, od, osh, oe, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL same_latency: got %0d cycles, expected 2", lat);
        end
        checks++;
        if (od !== d || osh !== 4'd0 || oe !== 1'b0) begin
            errors++;
            $display("FAIL same_stamp: got data=%h shift=%0d err=%b, expected data=%h shift=0 err=0",
                     od, osh, oe, d);
        end
    endtask

    task automatic test_intra_loop();
        logic [71:0] od; logic [3:0] osh; logic oe; int lat;
        logic [71:0] exp_d;
        exp_d = {56'h00FEDCBA987654, 4'd5, 12'd5};
        drive_beat({56'hFEDCBA98765432, 4'd3, 12'd5}, 4'd5, 12'd5, 1'b0, 4'h0, od, osh, oe, lat);
        checks++;
        if (od !== exp_d || osh !== 4'd2 || oe !== 1'b0) begin
            errors++;
            $display("FAIL intra_loop: got data=%h shift=%0d err=%b, expected data=%h shift=2 err=0",
                     od, osh, oe, exp_d);
        end
    endtask

    task automatic test_cross_loop_insert();
        logic [71:0] od; logic [3:0] osh; logic oe; int lat;
        logic [71:0] exp_d;
        exp_d = {56'h300FEDCBA98765, 4'd1, 12'd6};
        drive_beat({56'hFEDCBA98765432, 4'd12, 12'd5}, 4'd1, 12'd6, 1'b1, 4'h3, od, osh, oe, lat);
        checks++;
        if (od !== exp_d || osh !== 4'd3 || oe !== 1'b0) begin
            errors++;
            $display("FAIL cross_loop: got data=%h shift=%0d err=%b, expected data=%h shift=3 err=0",
                     od, osh, oe, exp_d);
        end
    endtask

    task automatic test_saturation();
        logic [71:0] od; logic [3:0] osh; logic oe; int lat;
        logic [71:0] exp_d;
        exp_d = {56'hA0000000000000, 4'd0, 12'd7};
        drive_beat({56'hFEDCBA98765432, 4'd0, 12'd5}, 4'd0, 12'd7, 1'b1, 4'hA, od, osh, oe, lat);
        checks++;
        if (od !== exp_d || osh !== 4'd14 || oe !== 1'b0) begin
            errors++;
            $display("FAIL saturation: got data=%h shift=%0d err=%b, expected data=%h shift=14 err=0",
                     od, osh, oe, exp_d);
        end
        // Delta of exactly NUM_BUCKETS: 5/0 -> 6/0, no insert.
        drive_beat({56'hFEDCBA98765432, 4'd0, 12'd5}, 4'd0, 12'd6, 1'b0, 4'h0, od, osh, oe, lat);
        checks++;
        if (od !== {56'h0, 4'd0, 12'd6} || osh !== 4'd14) begin
            errors++;
            $display("FAIL shift_exact14: got data=%h shift=%0d, expected data=%h shift=14",
                     od, osh, {56'h0, 4'd0, 12'd6});
        end
    endtask

    task automatic test_errors();
        logic [71:0] od; logic [3:0] osh; logic oe; int lat;
        logic [71:0] d;
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_before: got %b, expected 0", err_sticky);
        end
        d = {56'h123456789ABCDE, 4'd0, 12'd6};
        drive_beat(d, 4'd13, 12'd5, 1'b1, 4'hF, od, osh, oe, lat);
        checks++;
        if (od !== d || osh !== 4'd0 || oe !== 1'b1) begin
            errors++;
            $display("FAIL err_past: got data=%h shift=%0d err=%b, expected data=%h shift=0 err=1",
                     od, osh, oe, d);
        end
        @(negedge clk); #1;
        checks++;
        if (err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set: got %b, expected 1", err_sticky);
        end
        d = {56'hFEDCBA98765432, 4'd15, 12'd5};
        drive_beat(d, 4'd0, 12'd6, 1'b0, 4'h0, od, osh, oe, lat);
        checks++;
        if (od !== d || oe !== 1'b1 || osh !== 4'd0) begin
            errors++;
            $display("FAIL err_bucket15: got data=%h shift=%0d err=%b, expected data=%h shift=0 err=1",
                     od, osh, oe, d);
        end
        d = {56'h00000000000011, 4'd2, 12'd3};
        drive_beat(d, 4'd14, 12'd3, 1'b0, 4'h0, od, osh, oe, lat);
        checks++;
        if (od !== d || oe !== 1'b1) begin
            errors++;
            $display("FAIL err_cur14: got data=%h err=%b, expected data=%h err=1", od, oe, d);
        end
        // A clean beat must not clear the sticky flag.
        drive_beat({56'h0, 4'd1, 12'd1}, 4'd1, 12'd1, 1'b0, 4'h0, od, osh, oe, lat);
        @(negedge clk); #1;
        checks++;
        if (oe !== 1'b0 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sticky_hold: got err=%b sticky=%b, expected err=0 sticky=1", oe, err_sticky);
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] beats[4];
        logic [71:0] exp_d;
        int acc, got;
        beats[0] = {56'h11111111111111, 4'd2, 12'd2};
        beats[1] = {56'h22222222222222, 4'd2, 12'd2};
        beats[2] = {56'h33333333333333, 4'd2, 12'd2};
        beats[3] = {56'h44444444444444, 4'd2, 12'd2};
        exp_q.delete();
        acc = 0; got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 6);
            if (acc < 4) begin
                in_valid = 1'b1; in_data = beats[acc];
                in_cur_bucket = 4'd2; in_cur_loop = 12'd2; in_insert = 1'b0; in_mark = 4'h0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 2 || c == 5) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready_c%0d: got %b, expected 0", c, in_ready);
                end
            end
            if (c >= 2 && c < 6) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== beats[0]) begin
                    errors++;
                    $display("FAIL bp_hold_c%0d: got valid=%b data=%h, expected valid=1 data=%h",
                             c, out_valid, out_data, beats[0]);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: got data=%h, expected no beat", out_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (out_data !== exp_d) begin
                        errors++;
                        $display("FAIL bp_order: got %h, expected %h", out_data, exp_d);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(beats[acc]);
                acc++;
            end
        end
        checks++;
        if (got !== 4) begin
            errors++;
            $display("FAIL bp_count: got %0d beats, expected 4", got);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_dup: got out_valid=%b data=%h, expected 0", out_valid, out_data);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = {56'hABCDEF01234567, 4'd4, 12'd9};
            in_cur_bucket = 4'd4; in_cur_loop = 12'd9; in_insert = 1'b0; in_mark = 4'h0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 72'd0 || err_sticky !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_stall: got valid=%b data=%h sticky=%b in_ready=%b, expected 0 0 0 1",
                     out_valid, out_data, err_sticky, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale: got out_valid=%b data=%h, expected 0", out_valid, out_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_same_stamp();
        test_intra_loop();
        test_cross_loop_insert();
        test_saturation();
        test_errors();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
